// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB slave register file with RW/RO registers and wait states
//
// Parameters:
//   DWIDTH      data width in bits (multiple of 8)
//   AWIDTH      byte address width
//   NREGS       number of registers (1..256)
//   WAIT_STATES extra access-phase cycles per transfer (0..15)
//   RO_MASK     bit i set: register i is read-only, value taken from HW_IN slice i
//   RESET_VAL   reset value of RW register i in slice i
// Ports:
//   PCLK, PRESETn                   clock, synchronous active-low reset
//   PADDR, PWDATA, PWRITE, PSEL,
//   PENABLE                         APB request
//   PREADY, PRDATA, PSLVERR         APB response
//   HW_IN                           sources for read-only registers
//   REG_OUT                         current RW register values (RO slices are 0)
//   WR_STB                          one-cycle pulse per committed register write
module apb_slave_regfile #(
    parameter int                      DWIDTH      = 32,
    parameter int                      AWIDTH      = 32,
    parameter int                      NREGS       = 8,
    parameter int                      WAIT_STATES = 0,
    parameter logic [NREGS-1:0]        RO_MASK     = '0,
    parameter logic [NREGS*DWIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic [AWIDTH-1:0]       PADDR,
    input  logic [DWIDTH-1:0]       PWDATA,
    input  logic                    PWRITE,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    output logic                    PREADY,
    output logic [DWIDTH-1:0]       PRDATA,
    output logic                    PSLVERR,
    input  logic [NREGS*DWIDTH-1:0] HW_IN,
    output logic [NREGS*DWIDTH-1:0] REG_OUT,
    output logic [NREGS-1:0]        WR_STB
);

    localparam int NBYTES = DWIDTH / 8;
    localparam int IDXW   = (NREGS > 1) ? $clog2(NREGS) : 1;
    // Index is widened to at least 32 bits so the range check against NREGS
    // is exact even for narrow address buses.
    localparam int XW     = (AWIDTH > 32) ? AWIDTH : 32;

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [DWIDTH-1:0]   regs_q [NREGS];
    logic [NREGS-1:0]    wr_stb_q;
    logic [NREGS-1:0]    wr_stb_d;

    logic [AWIDTH-1:0]   idx_full;
    logic [XW-1:0]       idx_x;
    logic [IDXW-1:0]     idx_sel;
    logic                idx_oob;
    logic                ro_hit;
    logic                err;
    logic                pready;
    logic                commit;
    logic [DWIDTH-1:0]   rd_val;

    assign idx_full = PADDR / AWIDTH'(NBYTES);
    assign idx_x    = XW'(idx_full);
    assign idx_sel  = idx_x[IDXW-1:0];
    assign idx_oob  = (idx_x >= XW'(NREGS));

    // Read-only lookup and read mux; only meaningful when the index is in range.
    always_comb begin
        ro_hit = 1'b0;
        rd_val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (idx_sel == IDXW'(i)) begin
                ro_hit = RO_MASK[i];
                rd_val = RO_MASK[i] ? HW_IN[i*DWIDTH +: DWIDTH] : regs_q[i];
            end
        end
    end

    assign err    = idx_oob || (PWRITE && ro_hit);
    // Gated by PRESETn so the bus sees no response while reset is held,
    // even before the reset edge has cleared the state register.
    assign pready = PRESETn && (state_q == S_ACCESS) && PSEL && PENABLE && (cnt_q == 4'd0);
    assign commit = pready && PWRITE && !err;

    assign PREADY  = pready;
    assign PSLVERR = pready && err;
    assign PRDATA  = (pready && !PWRITE && !err) ? rd_val : '0;
    assign WR_STB  = wr_stb_q;

    always_comb begin
        wr_stb_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            wr_stb_d[i] = commit && (idx_sel == IDXW'(i));
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            wr_stb_q <= '0;
        end else begin
            wr_stb_q <= wr_stb_d;
            case (state_q)
                S_IDLE: begin
                    // PENABLE without a preceding setup phase is ignored.
                    if (PSEL && !PENABLE) begin
                        state_q <= S_ACCESS;
                        cnt_q   <= 4'(WAIT_STATES);
                    end
                end
                S_ACCESS: begin
                    if (!PSEL) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 4'd0;
                    end else if (PENABLE) begin
                        if (cnt_q == 4'd0) begin
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    // Read-only slots hold zero and are never written.
    always_ff @(posedge PCLK) begin
        for (int i = 0; i < NREGS; i++) begin
            if (!PRESETn) begin
                regs_q[i] <= RO_MASK[i] ? '0 : RESET_VAL[i*DWIDTH +: DWIDTH];
            end else if (commit && (idx_sel == IDXW'(i)) && !RO_MASK[i]) begin
                regs_q[i] <= PWDATA;
            end
        end
    end

    always_comb begin
        REG_OUT = '0;
        for (int i = 0; i < NREGS; i++) begin
            REG_OUT[i*DWIDTH +: DWIDTH] = RO_MASK[i] ? '0 : regs_q[i];
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - directed scoreboard testbench for apb_slave_regfile
module tb_apb_slave_regfile;

    localparam int NR = 8;
    localparam int DW = 32;
    localparam int WS = 2;
    localparam logic [NR-1:0]    ROM = 8'h04;
    localparam logic [NR*DW-1:0] RV  = {32'hA0000007, 32'hA0000006, 32'hA0000005, 32'hA0000004,
                                        32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};

    logic            clk = 1'b0;
    logic            rstn;
    logic [31:0]     paddr;
    logic [DW-1:0]   pwdata;
    logic            pwrite;
    logic            psel;
    logic            penable;
    logic            pready;
    logic [DW-1:0]   prdata;
    logic            pslverr;
    logic [NR*DW-1:0] hw_in;
    logic [NR*DW-1:0] reg_out;
    logic [NR-1:0]   wr_stb;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0] rd;
        logic          err;
        logic [NR-1:0] stb;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mdl [NR];

    always #5 clk = ~clk;

    apb_slave_regfile #(
        .DWIDTH(DW), .AWIDTH(32), .NREGS(NR), .WAIT_STATES(WS),
        .RO_MASK(ROM), .RESET_VAL(RV)
    ) dut (
        .PCLK(clk), .PRESETn(rstn), .PADDR(paddr), .PWDATA(pwdata),
        .PWRITE(pwrite), .PSEL(psel), .PENABLE(penable), .PREADY(pready),
        .PRDATA(prdata), .PSLVERR(pslverr), .HW_IN(hw_in), .REG_OUT(reg_out),
        .WR_STB(wr_stb)
    );

    task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] model_pack();
        logic [NR*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = ROM[i] ? '0 : mdl[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mdl[i] = ROM[i] ? '0 : RV[i*DW +: DW];
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [DW-1:0] wdata, input string tag);
        exp_t e;
        exp_t got;
        int   idx;
        int   n;
        logic done;
        logic commit;
        idx    = int'(addr / 4);
        e.err  = (idx >= NR) || (wr && ROM[idx[2:0]]);
        e.rd   = '0;
        e.stb  = '0;
        if (!wr && !e.err) e.rd = ROM[idx[2:0]] ? hw_in[idx*DW +: DW] : mdl[idx];
        commit = wr && !e.err;
        if (commit) e.stb = NR'(1) << idx;
        sb.push_back(e);

        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata;
        @(negedge clk);
        chk({tag, "_setup_pready"}, NR*DW'(pready), '0);
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        done = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (pready) done = 1'b1;
            else if (prdata !== '0 || pslverr !== 1'b0)
                chk({tag, "_wait_quiet"}, NR*DW'({pslverr, prdata}), '0);
        end
        chk({tag, "_ready_seen"}, NR*DW'(done), NR*DW'(1));
        got = sb.pop_front();
        if (done) begin
            chk({tag, "_latency"}, NR*DW'(n), NR*DW'(WS + 1));
            chk({tag, "_prdata"}, NR*DW'(prdata), NR*DW'(got.rd));
            chk({tag, "_pslverr"}, NR*DW'(pslverr), NR*DW'(got.err));
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        if (commit) mdl[idx] = wdata;
        @(negedge clk);
        chk({tag, "_wr_stb"}, NR*DW'(wr_stb), NR*DW'(got.stb));
        chk({tag, "_reg_out"}, reg_out, model_pack());
        @(negedge clk);
        chk({tag, "_wr_stb_clear"}, NR*DW'(wr_stb), '0);
    endtask

    initial begin
        rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; hw_in = '0;
        hw_in[2*DW +: DW] = 32'h12345678;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pready", NR*DW'(pready), '0);
        chk("rst_pslverr", NR*DW'(pslverr), '0);
        chk("rst_prdata", NR*DW'(prdata), '0);
        chk("rst_wr_stb", NR*DW'(wr_stb), '0);
        chk("rst_reg_out", reg_out, model_pack());
        @(posedge clk); #1;
        rstn = 1'b1;

        xfer(1'b1, 32'h4, 32'hDEADBEEF, "wr_r1");
        xfer(1'b0, 32'h4, '0, "rd_r1");
        xfer(1'b0, 32'h6, '0, "rd_r1_offset");
        xfer(1'b0, 32'h0, '0, "rd_r0_reset");
        xfer(1'b1, 32'h8, 32'hCAFEF00D, "wr_ro2");
        xfer(1'b0, 32'h8, '0, "rd_ro2");
        hw_in[2*DW +: DW] = 32'h0BADF00D;
        xfer(1'b0, 32'hA, '0, "rd_ro2_new");
        xfer(1'b0, 32'h20, '0, "rd_oob");
        xfer(1'b1, 32'h20, 32'h55555555, "wr_oob");
        xfer(1'b1, 32'h1C, 32'h76543210, "wr_r7");
        xfer(1'b0, 32'h1C, '0, "rd_r7");

        // aborted transfer, then PENABLE without setup must stay idle
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 32'h14; pwrite = 1'b1; pwdata = 32'h11111111;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        chk("abort_access_pready", NR*DW'(pready), '0);
        @(posedge clk); #1;
        psel = 1'b0;
        @(negedge clk);
        chk("abort_drop_pready", NR*DW'(pready), '0);
        @(posedge clk); #1;
        psel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_idle_penable", NR*DW'({pready, wr_stb}), '0);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("abort_reg_out", reg_out, model_pack());
        xfer(1'b1, 32'h14, 32'h22222222, "wr_r5_after_abort");

        // reset during a write's wait state
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 32'hC; pwrite = 1'b1; pwdata = 32'h33333333;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        chk("mid_rst_wait_pready", NR*DW'(pready), '0);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_outputs", NR*DW'({pready, pslverr, prdata}), '0);
        @(posedge clk); #1;
        rstn = 1'b1; psel = 1'b0; penable = 1'b0;
        model_reset();
        @(negedge clk);
        chk("mid_rst_wr_stb", NR*DW'(wr_stb), '0);
        chk("mid_rst_reg_out", reg_out, model_pack());
        xfer(1'b1, 32'hC, 32'h44444444, "wr_r3_post_rst");
        xfer(1'b0, 32'hC, '0, "rd_r3_post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 SHALL have parameter DWIDTH, default 32: data width in bits, a multiple of 8.
REQ-002 SHALL have parameter AWIDTH, default 32: address width in bits.
REQ-003 SHALL have parameter NREGS, default 8: number of registers, 1..256.
REQ-004 SHALL have parameter WAIT_STATES, default 0: extra access-phase cycles per transfer, 0..15.
REQ-005 SHALL have parameter RO_MASK, default 0 (NREGS bits): bit i set means register i is read-only and sourced from HW_IN.
REQ-006 SHALL have parameter RESET_VAL, default 0 (NREGS*DWIDTH bits): reset value of each RW register, register i in slice i.
REQ-007 SHALL have one clock and a synchronous, active-low reset, on the ports listed in REQ-008 and REQ-009.
REQ-008 PCLK  in  1  clock; all state updates on the rising edge.
REQ-009 PRESETn  in  1  reset; synchronous, active-low.
REQ-010 PADDR  in  AWIDTH  byte address.
REQ-011 PWDATA  in  DWIDTH  write data.
REQ-012 PWRITE  in  1  1 = write, 0 = read.
REQ-013 PSEL  in  1  slave select.
REQ-014 PENABLE  in  1  access phase.
REQ-015 PREADY  out  1  transfer completes this cycle.
REQ-016 PRDATA  out  DWIDTH  read data.
REQ-017 PSLVERR  out  1  transfer error.
REQ-018 HW_IN  in  NREGS*DWIDTH  value sources for RO registers, register i in slice i.
REQ-019 REG_OUT  out  NREGS*DWIDTH  current value of every RW register; RO slices read as 0.
REQ-020 WR_STB  out  NREGS  one-cycle pulse, bit i high on the cycle register i is written.

Function
REQ-021 SHALL compute register index idx = PADDR / (DWIDTH/8) and ignore the byte-offset bits.
REQ-022 SHALL implement an FSM with two states, IDLE and ACCESS.
REQ-023 In IDLE, PSEL=1 with PENABLE=0 (setup phase) SHALL move the FSM to ACCESS and load the wait counter with WAIT_STATES.
REQ-024 In ACCESS with PSEL=1 and PENABLE=1, the wait counter SHALL decrement by 1 per cycle while nonzero.
REQ-025 PREADY SHALL equal (state==ACCESS && PSEL && PENABLE && counter==0), combinationally from registered state.
REQ-026 With WAIT_STATES=N, PREADY SHALL first go high on access-phase cycle N+1, counting the first access cycle as 1.
REQ-027 In ACCESS, PREADY=1 SHALL return the FSM to IDLE on the next edge, so back-to-back transfers need a new setup phase.
REQ-028 In ACCESS, PSEL=0 (aborted transfer) SHALL return the FSM to IDLE with no register update and no WR_STB pulse.
REQ-029 An error SHALL be flagged when idx >= NREGS, or when PWRITE=1 and RO_MASK[idx]=1.
REQ-030 PSLVERR SHALL equal PREADY && error, and SHALL be 0 whenever PREADY=0.
REQ-031 A write SHALL commit at the edge ending a PREADY=1 cycle when PWRITE=1 and there is no error: reg[idx] takes PWDATA, and WR_STB[idx] is high the following cycle only.
REQ-032 An errored write SHALL leave all registers unchanged and SHALL produce no WR_STB pulse.
REQ-033 When PREADY=1, PWRITE=0 and there is no error, PRDATA SHALL be reg[idx] for an RW register or the HW_IN slice for an RO register.
REQ-034 PRDATA SHALL be 0 in every other cycle, including error reads.
REQ-035 HW_IN SHALL be sampled combinationally during the PREADY cycle.
REQ-036 PADDR, PWRITE and PWDATA SHALL be assumed stable from setup to completion; the slave SHALL use their values in the PREADY cycle.
REQ-037 PENABLE=1 while in IDLE (protocol violation) SHALL be ignored, with the FSM staying in IDLE.

Reset
REQ-038 PRESETn=0 at an edge SHALL force: FSM to IDLE, wait counter to 0, RW registers to RESET_VAL, WR_STB to 0.
REQ-039 During reset, PREADY, PSLVERR and PRDATA SHALL be 0.
REQ-040 Reset asserted mid-transfer SHALL abort the transfer with no write commit; the master must restart from a setup phase.

Verification
REQ-041 Scenario: WAIT_STATES=0, write 0xDEADBEEF to PADDR 0x4, then read it -> PREADY on the first access cycle, WR_STB[1] pulses once, PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-042 Scenario: WAIT_STATES=3, read of register 0 -> PREADY low for 3 access cycles and high on the 4th; PRDATA=RESET_VAL[0] only in the 4th.
REQ-043 Scenario: RO_MASK=0x4, HW_IN slice 2=0x12345678; write PADDR 0x8, then read PADDR 0x8 -> write gives PSLVERR=1 with no WR_STB; read gives 0x12345678 with PSLVERR=0.
REQ-044 Scenario: NREGS=8, read and write at PADDR 0x20 -> PSLVERR=1, PRDATA=0, no register changes.
REQ-045 Scenario: PSEL dropped mid-access with WAIT_STATES=2 -> FSM returns to IDLE, no commit; the next full transfer completes normally.
REQ-046 Scenario: PRESETn low during a write's wait state -> register keeps RESET_VAL, PREADY=0; the first post-reset transfer completes normally.
